// File: rtl/systolic_feeder.sv
// systolic_feeder: captures an N x N operand matrix row-major, then streams it skewed (lane i delayed i cycles).
// Optional stall input is enabled by defining SYSTOLIC_FEEDER_STALL_EN.
module systolic_feeder #(
  parameter int N      = 2,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [DATA_W-1:0]   load_data,
  input  logic                start,
`ifdef SYSTOLIC_FEEDER_STALL_EN
  input  logic                stall,
`endif
  output logic                busy,
  output logic                done,
  output logic [N*DATA_W-1:0] feed_data,
  output logic [N-1:0]        feed_valid
);

  localparam int WORDS  = N * N;
  localparam int CNT_W  = $clog2(WORDS + 1);
  localparam int ADDR_W = $clog2(WORDS);
  localparam int BEAT_W = $clog2(2 * N);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * N - 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_LOADED = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]          state;
  logic [CNT_W-1:0]    word_cnt;
  logic [BEAT_W-1:0]   beat;
  logic [DATA_W-1:0]   mem [WORDS];
  logic                stall_i;
  logic                load_fire;
  logic [BEAT_W-1:0]   beat_sel;
  logic [N*DATA_W-1:0] beat_data;
  logic [N-1:0]        beat_valid;

`ifdef SYSTOLIC_FEEDER_STALL_EN
  assign stall_i = stall;
`else
  assign stall_i = 1'b0;
`endif

  assign load_ready = (state == S_IDLE) || (state == S_LOAD);
  assign busy       = (state == S_LOAD) || (state == S_LOADED) || (state == S_STREAM);
  assign load_fire  = load_valid && load_ready;

  // NOTE: the matrix store has no reset; its contents only matter after a complete load.
  always_ff @(posedge clk) begin
    if (load_fire) mem[word_cnt[ADDR_W-1:0]] <= load_data;
  end

  // Beat about to be registered: 0 on the start edge, otherwise the successor of the current beat.
  always_comb begin
    beat_data  = '0;
    beat_valid = '0;
    beat_sel   = (state == S_LOADED) ? '0 : beat + BEAT_W'(1);
    for (int i = 0; i < N; i++) begin
      for (int r = 0; r < N; r++) begin
        if (int'(beat_sel) == r + i) begin
          beat_valid[i]                 = 1'b1;
          beat_data[i*DATA_W +: DATA_W] = mem[ADDR_W'(r * N + i)];
        end
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      word_cnt   <= '0;
      beat       <= '0;
      feed_data  <= '0;
      feed_valid <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_fire) begin
            word_cnt <= CNT_W'(1);
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (load_fire) begin
            if (word_cnt == CNT_W'(WORDS - 1)) begin
              word_cnt <= '0;
              state    <= S_LOADED;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        S_LOADED: begin
          if (start) begin
            beat       <= '0;
            feed_data  <= beat_data;
            feed_valid <= beat_valid;
            state      <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (!stall_i) begin
            if (beat == LAST_BEAT) begin
              beat       <= '0;
              feed_data  <= '0;
              feed_valid <= '0;
              done       <= 1'b1;
              state      <= S_DONE;
            end else begin
              beat       <= beat + BEAT_W'(1);
              feed_data  <= beat_data;
              feed_valid <= beat_valid;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder: N=2 and N=3 instances checked against a skew model of the matrix.
module tb_systolic_feeder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mat [9];
  logic use3 = 1'b0;

  logic        lv2 = 1'b0, st2 = 1'b0;
  logic [7:0]  ld2 = 8'h00;
  logic        lr2, busy2, done2;
  logic [15:0] fd2;
  logic [1:0]  fv2;

  logic        lv3 = 1'b0, st3 = 1'b0;
  logic [7:0]  ld3 = 8'h00;
  logic        lr3, busy3, done3;
  logic [23:0] fd3;
  logic [2:0]  fv3;
`ifdef SYSTOLIC_FEEDER_STALL_EN
  logic        stall3 = 1'b0;
`endif

  systolic_feeder #(.N(2), .DATA_W(8)) dut2 (
    .clk(clk), .reset(reset), .load_valid(lv2), .load_ready(lr2), .load_data(ld2),
    .start(st2),
`ifdef SYSTOLIC_FEEDER_STALL_EN
    .stall(1'b0),
`endif
    .busy(busy2), .done(done2), .feed_data(fd2), .feed_valid(fv2)
  );

  systolic_feeder #(.N(3), .DATA_W(8)) dut3 (
    .clk(clk), .reset(reset), .load_valid(lv3), .load_ready(lr3), .load_data(ld3),
    .start(st3),
`ifdef SYSTOLIC_FEEDER_STALL_EN
    .stall(stall3),
`endif
    .busy(busy3), .done(done3), .feed_data(fd3), .feed_valid(fv3)
  );

  logic [7:0] o_data [3];
  logic [2:0] o_valid;
  logic       o_done, o_ready, o_busy;

  always_comb begin
    o_data[0] = fd2[7:0];
    o_data[1] = fd2[15:8];
    o_data[2] = 8'h00;
    o_valid   = {1'b0, fv2};
    o_done    = done2;
    o_ready   = lr2;
    o_busy    = busy2;
    if (use3) begin
      o_data[0] = fd3[7:0];
      o_data[1] = fd3[15:8];
      o_data[2] = fd3[23:16];
      o_valid   = fv3;
      o_done    = done3;
      o_ready   = lr3;
      o_busy    = busy3;
    end
  end

  // Reference: at beat t, lane i carries M[t-i][i] when that row exists.
  function automatic int cur_n();
    return use3 ? 3 : 2;
  endfunction

  function automatic logic [2:0] model_valid(input int n, input int t);
    logic [2:0] v;
    v = 3'b000;
    for (int i = 0; i < n; i++)
      if (t - i >= 0 && t - i < n) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] model_data(input int n, input int t, input int i);
    if (t - i >= 0 && t - i < n) return mat[(t - i) * n + i][7:0];
    return 8'h00;
  endfunction

  task automatic drive(input logic lv, input logic [7:0] ld, input logic st);
    if (use3) begin lv3 = lv; ld3 = ld; st3 = st; end
    else      begin lv2 = lv; ld2 = ld; st2 = st; end
  endtask

  task automatic load_words(input int from, input int to);
    for (int k = from; k < to; k++) begin
      drive(1'b1, mat[k][7:0], 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  // Pulses start from LOADED and follows the whole stream through DONE back to IDLE.
  task automatic expect_stream(input string name, input logic hold_lv);
    int n;
    n = cur_n();
    drive(hold_lv, 8'd9, 1'b1);
    @(negedge clk);
    drive(hold_lv, 8'd9, 1'b0);
    for (int t = 0; t < 2 * n - 1; t++) begin
      checks++;
      if (o_valid !== model_valid(n, t)) begin
        errors++;
        $display("FAIL %s valid beat %0d: got %b expected %b", name, t, o_valid, model_valid(n, t));
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (o_data[i] !== model_data(n, t, i)) begin
          errors++;
          $display("FAIL %s lane%0d beat %0d: got %0d expected %0d", name, i, t, o_data[i], model_data(n, t, i));
        end
      end
      if (hold_lv) begin
        checks++;
        if (o_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s load_ready in stream: got %b expected 0", name, o_ready);
        end
      end
      @(negedge clk);
    end
    drive(1'b0, 8'h00, 1'b0);
    checks++;
    if (o_valid !== 3'b000 || o_done !== 1'b1) begin
      errors++;
      $display("FAIL %s done beat: got valid=%b done=%b expected valid=000 done=1", name, o_valid, o_done);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: got done=%b ready=%b busy=%b expected 0 1 0", name, o_done, o_ready, o_busy);
    end
  endtask

  task automatic test_reset();
    use3 = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 3'b000 || o_done !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1 || fd2 !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b done=%b busy=%b ready=%b data=%h expected 00 0 0 1 0000",
               o_valid, o_done, o_busy, o_ready, fd2);
    end
    reset = 1'b0;
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1 || o_valid !== 3'b000) begin
      errors++;
      $display("FAIL start_in_idle: got busy=%b ready=%b valid=%b expected 0 1 00", o_busy, o_ready, o_valid);
    end
  endtask

  task automatic test_basic();
    use3 = 1'b0;
    mat[0] = 1; mat[1] = 2; mat[2] = 3; mat[3] = 4;
    load_words(0, 4);
    checks++;
    if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL loaded_state: got ready=%b busy=%b expected 0 1", o_ready, o_busy);
    end
    expect_stream("basic", 1'b0);
  endtask

  task automatic test_zero_data();
    use3 = 1'b0;
    mat[0] = 0; mat[1] = 0; mat[2] = 0; mat[3] = 5;
    load_words(0, 4);
    expect_stream("zeros", 1'b0);
  endtask

  task automatic test_start_in_load();
    use3 = 1'b0;
    mat[0] = 1; mat[1] = 2; mat[2] = 3; mat[3] = 4;
    drive(1'b1, mat[0][7:0], 1'b0);
    @(negedge clk);
    drive(1'b1, mat[1][7:0], 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 3'b000 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_in_load: got busy=%b valid=%b ready=%b expected 1 00 1", o_busy, o_valid, o_ready);
    end
    load_words(2, 4);
    expect_stream("start_in_load", 1'b0);
  endtask

  task automatic test_load_blocked();
    use3 = 1'b0;
    mat[0] = 1; mat[1] = 2; mat[2] = 3; mat[3] = 4;
    load_words(0, 4);
    drive(1'b1, 8'd9, 1'b0);
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL load_blocked: got ready=%b busy=%b expected 0 1", o_ready, o_busy);
    end
    expect_stream("load_blocked", 1'b1);
  endtask

  task automatic test_reset_mid_stream();
    use3 = 1'b0;
    for (int k = 0; k < 4; k++) mat[k] = int'($urandom_range(0, 255));
    load_words(0, 4);
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (o_valid !== 3'b000 || o_done !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got valid=%b done=%b ready=%b busy=%b expected 00 0 1 0", o_valid, o_done, o_ready, o_busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got done=%b ready=%b expected 0 1", o_done, o_ready);
    end
    for (int k = 0; k < 4; k++) mat[k] = int'($urandom_range(0, 255));
    load_words(0, 4);
    expect_stream("after_reset", 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n;
      int idle;
      use3 = (it % 2) == 1;
      n = cur_n();
      for (int k = 0; k < n * n; k++) mat[k] = int'($urandom_range(0, 255));
      load_words(0, n * n);
      idle = int'($urandom_range(0, 3));
      for (int c = 0; c < idle; c++) begin
        drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
        @(negedge clk);
      end
      drive(1'b0, 8'h00, 1'b0);
      expect_stream(use3 ? "random_n3" : "random_n2", 1'b0);
    end
    use3 = 1'b0;
  endtask

`ifdef SYSTOLIC_FEEDER_STALL_EN
  task automatic test_stall();
    int seq_t [8] = '{0, 1, 2, 2, 2, 3, 4, 4};
    bit seq_s [8] = '{0, 0, 1, 1, 0, 0, 1, 0};
    use3 = 1'b1;
    for (int k = 0; k < 9; k++) mat[k] = k + 1;
    load_words(0, 9);
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 8; c++) begin
      stall3 = seq_s[c];
      checks++;
      if (o_valid !== model_valid(3, seq_t[c])) begin
        errors++;
        $display("FAIL stall valid cycle %0d: got %b expected %b", c, o_valid, model_valid(3, seq_t[c]));
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_data[i] !== model_data(3, seq_t[c], i)) begin
          errors++;
          $display("FAIL stall lane%0d cycle %0d: got %0d expected %0d", i, c, o_data[i], model_data(3, seq_t[c], i));
        end
      end
      @(negedge clk);
    end
    stall3 = 1'b0;
    checks++;
    if (o_valid !== 3'b000 || o_done !== 1'b1) begin
      errors++;
      $display("FAIL stall done: got valid=%b done=%b expected 000 1", o_valid, o_done);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall idle: got done=%b ready=%b expected 0 1", o_done, o_ready);
    end
    use3 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_data();
    test_start_in_load();
    test_load_blocked();
    test_reset_mid_stream();
    test_random();
`ifdef SYSTOLIC_FEEDER_STALL_EN
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
